// File: rtl/ldtu_stream_decoder_if.sv
// Word-in / sample-out handshake bundle for the LiTe-DTU stream decoder.
interface ldtu_stream_decoder_if #(
    parameter int ERR_W = 8
);
    logic [31:0]      DATA_in;
    logic             DATA_valid;
    logic             DATA_ready;
    logic [12:0]      sample_out;
    logic             sample_bsl;
    logic             sample_bc0;
    logic             sample_valid;
    logic             sample_ready;
    logic             err_flag;
    logic [ERR_W-1:0] err_count;

    modport slave (
        input  DATA_in, DATA_valid, sample_ready,
        output DATA_ready, sample_out, sample_bsl, sample_bc0,
        output sample_valid, err_flag, err_count
    );

    modport master (
        output DATA_in, DATA_valid, sample_ready,
        input  DATA_ready, sample_out, sample_bsl, sample_bc0,
        input  sample_valid, err_flag, err_count
    );
endinterface

// File: rtl/ldtu_stream_decoder.sv
// LiTe-DTU 32-bit word unpacker: classifies words, emits one sample per clock.
module ldtu_stream_decoder #(
    parameter int          N_BSL     = 5,
    parameter int          N_SIG     = 2,
    parameter int          ERR_W     = 8,
    parameter logic [31:0] IDLE_WORD = 32'hEAAAEAAA
) (
    input logic CLK,
    input logic rst_b,
    ldtu_stream_decoder_if.slave bus
);
    typedef enum logic {S_EMPTY, S_UNPACK} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_word;
    logic             r_bsl;
    logic [2:0]       r_rem;
    logic             r_pend;
    logic             r_mark;
    logic             r_alive;
    logic             r_err_flag;
    logic [ERR_W-1:0] r_err_cnt;

    logic        w_idle, w_bsl, w_sig, w_one, w_part, w_hdr;
    logic        w_data, w_bad;
    logic [3:0]  w_n;
    logic [31:0] w_ld_word;
    logic [2:0]  w_ld_rem;
    logic        w_ld_bsl;
    logic        w_valid, w_ready;
    logic        w_last, w_s_xfer, w_d_xfer, w_load;

    assign w_n = bus.DATA_in[27:24];

    always_comb begin
        w_idle = bus.DATA_in == IDLE_WORD;
        w_bsl  = !w_idle && bus.DATA_in[31:30] == 2'b01;
        w_sig  = bus.DATA_in[31:26] == 6'b001010;
        w_one  = bus.DATA_in[31:26] == 6'b001011;
        w_part = !w_idle && bus.DATA_in[31:28] == 4'b1110
                 && w_n != 4'd0 && w_n <= 4'd4;
        w_hdr  = bus.DATA_in[31:28] == 4'b1101;
        w_data = w_bsl | w_sig | w_one | w_part;
        w_bad  = !(w_idle | w_data | w_hdr);
    end

    always_comb begin
        w_ld_word = 32'd0;
        w_ld_rem  = 3'd0;
        w_ld_bsl  = 1'b0;
        unique case (1'b1)
            w_bsl: begin
                w_ld_word = {2'b00, bus.DATA_in[29:0]};
                w_ld_rem  = 3'(N_BSL);
                w_ld_bsl  = 1'b1;
            end
            w_sig: begin
                w_ld_word = {6'd0, bus.DATA_in[25:0]};
                w_ld_rem  = 3'(N_SIG);
            end
            w_one: begin
                w_ld_word = {19'd0, bus.DATA_in[12:0]};
                w_ld_rem  = 3'd1;
            end
            w_part: begin
                w_ld_word = {8'd0, bus.DATA_in[23:0]};
                w_ld_rem  = w_n[2:0];
                w_ld_bsl  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_last   = r_rem == 3'd1;
    assign w_s_xfer = w_valid && bus.sample_ready;
    assign w_d_xfer = bus.DATA_valid && w_ready;
    assign w_load   = w_d_xfer && w_data;

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) r_state <= S_EMPTY;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_EMPTY:  if (w_load) w_next = S_UNPACK;
            S_UNPACK: if (w_s_xfer && w_last)
                          w_next = w_load ? S_UNPACK : S_EMPTY;
            default:  w_next = S_EMPTY;
        endcase
    end

    // Ready on the last slot comes straight from sample_ready: no bubble.
    always_comb begin
        w_valid = 1'b0;
        w_ready = 1'b0;
        unique case (r_state)
            S_EMPTY:  w_ready = r_alive;
            S_UNPACK: begin
                w_valid = 1'b1;
                w_ready = r_alive && w_last && bus.sample_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            r_word <= 32'd0;
            r_bsl  <= 1'b0;
            r_rem  <= 3'd0;
            r_mark <= 1'b0;
        end else if (w_load) begin
            r_word <= w_ld_word;
            r_bsl  <= w_ld_bsl;
            r_rem  <= w_ld_rem;
            r_mark <= r_pend && !(w_s_xfer && r_mark);
        end else if (w_s_xfer) begin
            r_word <= r_bsl ? (r_word >> 6) : (r_word >> 13);
            r_rem  <= r_rem - 3'd1;
            r_mark <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            r_pend     <= 1'b0;
            r_alive    <= 1'b0;
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_alive    <= 1'b1;
            r_err_flag <= w_d_xfer && w_bad;
            if (w_d_xfer && w_hdr)
                r_pend <= 1'b1;
            else if (w_s_xfer && r_mark)
                r_pend <= 1'b0;
            if (w_d_xfer && w_bad && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.DATA_ready   = w_ready;
    assign bus.sample_valid = w_valid;
    assign bus.sample_out   = r_bsl ? {7'd0, r_word[5:0]} : r_word[12:0];
    assign bus.sample_bsl   = r_bsl;
    assign bus.sample_bc0   = r_mark;
    assign bus.err_flag     = r_err_flag;
    assign bus.err_count    = r_err_cnt;
endmodule

// File: tb/tb_ldtu_stream_decoder.sv
// Bench for ldtu_stream_decoder: directed and random words against a
// queue-based model of the word formats.
module tb_ldtu_stream_decoder;
    localparam logic [31:0] IDLE = 32'hEAAAEAAA;

    logic CLK = 1'b0;
    logic rst_b = 1'b1;
    always #5 CLK = ~CLK;

    ldtu_stream_decoder_if #(.ERR_W(8)) bus ();

    ldtu_stream_decoder #(
        .N_BSL(5), .N_SIG(2), .ERR_W(8), .IDLE_WORD(IDLE)
    ) u_dut (
        .CLK(CLK),
        .rst_b(rst_b),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] wq[$];
    logic [14:0] sq[$];
    logic        pend = 1'b0;
    logic        exp_flag = 1'b0;
    logic        alive = 1'b0;
    logic [7:0]  exp_cnt = 8'd0;
    int          rmode = 0;
    logic        tog = 1'b0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_word(input logic [31:0] w, output bit bad);
        int n;
        bit b;
        logic [31:0] s;
        bad = 0;
        n = 0;
        b = 0;
        if (w == IDLE) return;
        else if (w[31:30] == 2'b01) begin n = 5; b = 1; end
        else if (w[31:26] == 6'b001010) n = 2;
        else if (w[31:26] == 6'b001011) n = 1;
        else if (w[31:28] == 4'hE && w[27:24] >= 4'd1 && w[27:24] <= 4'd4) begin
            n = int'(w[27:24]);
            b = 1;
        end
        else if (w[31:28] == 4'hD) pend = 1'b1;
        else bad = 1;
        for (int i = 0; i < n; i++) begin
            s = b ? (w >> (6 * i)) & 32'h3F : (w >> (13 * i)) & 32'h1FFF;
            sq.push_back({(i == 0) && pend, b, s[12:0]});
        end
        if (n > 0) pend = 1'b0;
    endtask

    task automatic drive();
        tog = ~tog;
        bus.DATA_valid = wq.size() != 0;
        bus.DATA_in = (wq.size() != 0) ? wq[0] : 32'd0;
        case (rmode)
            0: bus.sample_ready = 1'b1;
            1: bus.sample_ready = tog;
            default: bus.sample_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic cycle();
        bit ev, er, sx, dx, bad;
        @(negedge CLK);
        ev = sq.size() != 0;
        er = alive && (sq.size() == 0 || (sq.size() == 1 && bus.sample_ready));
        chk("sample_valid", bus.sample_valid, ev);
        chk("data_ready", bus.DATA_ready, er);
        chk("err_flag", bus.err_flag, exp_flag);
        chk("err_count", bus.err_count, exp_cnt);
        if (ev)
            chk("sample", {bus.sample_bc0, bus.sample_bsl, bus.sample_out}, sq[0]);
        sx = ev && bus.sample_ready;
        dx = bus.DATA_valid && er;
        exp_flag = 1'b0;
        if (sx) void'(sq.pop_front());
        if (dx) begin
            model_word(wq.pop_front(), bad);
            if (bad) begin
                exp_flag = 1'b1;
                if (exp_cnt != 8'hFF) exp_cnt++;
            end
        end
        @(posedge CLK);
        if (rst_b) alive = 1'b1;
        #1;
        drive();
    endtask

    task automatic drain(string tag, int max);
        int n = 0;
        while ((wq.size() != 0 || sq.size() != 0) && n < max) begin
            cycle();
            n++;
        end
        chk(tag, wq.size() + sq.size(), 0);
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        #1;
        chk("rst_valid", bus.sample_valid, 1'b0);
        chk("rst_ready", bus.DATA_ready, 1'b0);
        chk("rst_out", bus.sample_out, 13'd0);
        chk("rst_bsl", bus.sample_bsl, 1'b0);
        chk("rst_bc0", bus.sample_bc0, 1'b0);
        chk("rst_flag", bus.err_flag, 1'b0);
        chk("rst_cnt", bus.err_count, 8'd0);
        wq.delete();
        sq.delete();
        pend = 1'b0;
        exp_flag = 1'b0;
        exp_cnt = 8'd0;
        alive = 1'b0;
        bus.DATA_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        rst_b = 1'b1;
        drive();
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0, 7: return {2'b01, 30'($urandom)};
            1: return {6'b001010, 26'($urandom)};
            2: return {6'b001011, 26'($urandom)};
            3: return {4'hE, 4'($urandom_range(0, 6)), 24'($urandom)};
            4: return {4'hD, 28'($urandom)};
            5: return IDLE;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        bus.DATA_in = 32'd0;
        bus.DATA_valid = 1'b0;
        bus.sample_ready = 1'b1;
        #2;
        do_reset();

        rmode = 0;
        wq.push_back({2'b01, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1});
        drain("bsl_done", 20);

        wq.push_back({6'b001010, 13'h1ABC, 13'h0123});
        wq.push_back({6'b001010, 13'h0FFF, 13'h1000});
        drain("sig_done", 20);

        wq.push_back(32'hD000_0000);
        wq.push_back(IDLE);
        wq.push_back({4'hE, 4'd3, 6'd0, 6'd9, 6'd8, 6'd7});
        drain("bc0_done", 20);

        wq.push_back(32'hF000_0000);
        wq.push_back({4'hE, 4'd0, 24'h000000});
        drain("err_done", 20);
        chk("err_cnt_two", bus.err_count, 8'd2);

        repeat (256) wq.push_back(32'hF000_0000);
        drain("sat_done", 400);
        chk("err_cnt_sat", bus.err_count, 8'hFF);

        rmode = 1;
        wq.push_back({2'b01, 30'($urandom)});
        drain("toggle_done", 40);

        rmode = 0;
        wq.push_back({2'b01, 30'($urandom)});
        n = 0;
        while (sq.size() != 3 && n < 20) begin
            cycle();
            n++;
        end
        chk("mid_reached", sq.size(), 3);
        do_reset();
        wq.push_back({6'b001010, 26'($urandom)});
        drain("post_rst_done", 20);

        rmode = 2;
        repeat (300) wq.push_back(rand_word());
        drain("rand_done", 5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
